// File: rtl/fft_mag_unit.sv
// fft_mag_unit: alpha-max-plus-beta-min magnitude of FFT bins.
// Each result is tagged with its bin index and an end-of-frame flag.
// Results are queued in an output FIFO so the consumer can stall.
module fft_mag_unit #(
  parameter int DATA_WIDTH    = 16,
  parameter int LOG2_POINTS   = 10,
  parameter int HALF_SPECTRUM = 1,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_WIDTH-1:0]  in_real,
  input  logic signed [DATA_WIDTH-1:0]  in_imag,
  output logic                          mag_valid,
  input  logic                          mag_ready,
  output logic [DATA_WIDTH-1:0]         mag_data,
  output logic [LOG2_POINTS-1:0]        mag_index,
  output logic                          mag_last
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int N       = 1 << LOG2_POINTS;
  localparam int LAST_I  = (HALF_SPECTRUM != 0) ? (N / 2 - 1) : (N - 1);
  localparam int ENTRY_W = DATA_WIDTH + LOG2_POINTS + 1;

  localparam logic [LOG2_POINTS-1:0]       LAST_IDX = LOG2_POINTS'(LAST_I);
  localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0]        MAX_POS  = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [CNT_W-1:0]             READY_MAX = CNT_W'(FIFO_DEPTH - 4);

  // Absolute value; the most negative code has no positive twin and clips.
  function automatic logic [DATA_WIDTH-1:0] sat_abs(input logic signed [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-1:0] r;
    if (x == MOST_NEG)
      r = MAX_POS;
    else if (x[DATA_WIDTH-1])
      r = $unsigned(-x);
    else
      r = $unsigned(x);
    return r;
  endfunction

  // max + 3/8 min; the worst case fits DATA_WIDTH bits, so no clipping.
  function automatic logic [DATA_WIDTH-1:0] amax_bmin(input logic [DATA_WIDTH-1:0] mx,
                                                       input logic [DATA_WIDTH-1:0] mn);
    return mx + (mn >> 2) + (mn >> 3);
  endfunction

  logic                   accept;
  logic                   fwd;
  logic [LOG2_POINTS-1:0] bin_cnt_q, bin_cnt_d;

  logic                   vld_p1, vld_p2, vld_p3;
  logic [DATA_WIDTH-1:0]  abs_re_p1, abs_im_p1;
  logic [DATA_WIDTH-1:0]  max_p2, min_p2;
  logic [DATA_WIDTH-1:0]  mag_p3;
  logic [LOG2_POINTS-1:0] idx_p1, idx_p2, idx_p3;
  logic                   last_p1, last_p2, last_p3;

  logic [ENTRY_W-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   push, pop;
  logic [ENTRY_W-1:0]     rd_entry;

  assign accept = in_valid && in_ready;
  assign fwd    = (HALF_SPECTRUM == 0) || !bin_cnt_q[LOG2_POINTS-1];

  // Bin counter advances only on accepted bins and wraps at N.
  always_comb begin
    bin_cnt_d = bin_cnt_q;
    if (accept) bin_cnt_d = bin_cnt_q + LOG2_POINTS'(1);
  end

  // Control state: bin counter and the valid bit travelling with each stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_cnt_q <= '0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      vld_p3    <= 1'b0;
    end else begin
      bin_cnt_q <= bin_cnt_d;
      vld_p1    <= accept && fwd;
      vld_p2    <= vld_p1;
      vld_p3    <= vld_p2;
    end
  end

  // Datapath registers; qualified by the vld_pN bits, so left unreset.
  always_ff @(posedge clk) begin
    // Stage 1: saturating absolute value of each component
    abs_re_p1 <= sat_abs(in_real);
    abs_im_p1 <= sat_abs(in_imag);
    idx_p1    <= bin_cnt_q;
    last_p1   <= (bin_cnt_q == LAST_IDX);
    // Stage 2: order the two magnitudes
    if (abs_re_p1 >= abs_im_p1) begin
      max_p2 <= abs_re_p1;
      min_p2 <= abs_im_p1;
    end else begin
      max_p2 <= abs_im_p1;
      min_p2 <= abs_re_p1;
    end
    idx_p2    <= idx_p1;
    last_p2   <= last_p1;
    // Stage 3: alpha-max-plus-beta-min
    mag_p3    <= amax_bmin(max_p2, min_p2);
    idx_p3    <= idx_p2;
    last_p3   <= last_p2;
  end

  assign push = vld_p3;
  assign pop  = mag_valid && mag_ready;

  // Occupancy bookkeeping; simultaneous push and pop leaves it unchanged.
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO pointers and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {last_p3, idx_p3, mag_p3};
  end

  // Head entry is masked to zero while empty so idle outputs are defined.
  assign rd_entry  = mem_q[rd_ptr_q];
  assign mag_valid = (cnt_q != '0);
  assign mag_data  = mag_valid ? rd_entry[DATA_WIDTH-1:0] : '0;
  assign mag_index = mag_valid ? rd_entry[DATA_WIDTH +: LOG2_POINTS] : '0;
  assign mag_last  = mag_valid && rd_entry[ENTRY_W-1];

  // Room for three in-flight results plus the bin accepted this cycle.
  assign in_ready  = (cnt_q <= READY_MAX);

endmodule
